// File: rtl/fibo_pkg.sv
// Shared definitions for the Fibonacci request scheduler: widths, FSM states,
// the response record and the round-robin pointer helper.
package fibo_pkg;

  localparam int IDX_W       = 5;
  localparam int FIBO_W_DFLT = 16;
  localparam int ID_W_MAX    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } fibo_state_t;

  typedef struct packed {
    logic [ID_W_MAX-1:0]    id;
    logic [FIBO_W_DFLT-1:0] data;
    logic                   ovf;
  } fibo_rsp_t;

  // Requester that gets first look on the next scan, after the one just granted.
  function automatic int unsigned rr_next(input int unsigned granted,
                                          input int unsigned n_req);
    return (granted + 1 == n_req) ? 0 : granted + 1;
  endfunction

endpackage

// File: rtl/fibo_sched_if.sv
// Request/grant and valid/ready response bundle between clients and fibo_sched.
interface fibo_sched_if #(
  parameter int N_REQ  = 4,
  parameter int ID_W   = $clog2(N_REQ),
  parameter int FIBO_W = fibo_pkg::FIBO_W_DFLT
) ();

  logic [N_REQ-1:0]                 req;
  logic [N_REQ*fibo_pkg::IDX_W-1:0] req_idx;
  logic [N_REQ-1:0]                 gnt;
  logic                             busy;
  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [ID_W-1:0]                  rsp_id;
  logic [FIBO_W-1:0]                rsp_data;
  logic                             rsp_ovf;

  modport master (
    output req, req_idx, rsp_ready,
    input  gnt, busy, rsp_valid, rsp_id, rsp_data, rsp_ovf
  );

  modport slave (
    input  req, req_idx, rsp_ready,
    output gnt, busy, rsp_valid, rsp_id, rsp_data, rsp_ovf
  );

endinterface

// File: rtl/fibo_core.sv
// Iterative Fibonacci datapath: a/b pair stepped cnt times after a load.
// Define FIBO_SAT_EN to add sticky overflow flags with all-ones saturation.
module fibo_core import fibo_pkg::*; #(
  parameter int FIBO_W = FIBO_W_DFLT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [IDX_W-1:0]  idx,
  input  logic              step,
  output logic              done,
  output logic [FIBO_W-1:0] result,
  output logic              ovf
);

  logic [FIBO_W-1:0] a_reg;
  logic [FIBO_W-1:0] b_reg;
  logic [FIBO_W-1:0] b_next;
  logic [IDX_W-1:0]  cnt_reg;

  assign done = (cnt_reg == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg   <= '0;
      b_reg   <= FIBO_W'(1);
      cnt_reg <= '0;
    end else if (load) begin
      a_reg   <= '0;
      b_reg   <= FIBO_W'(1);
      cnt_reg <= idx;
    end else if (step) begin
      a_reg   <= b_reg;
      b_reg   <= b_next;
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

`ifdef FIBO_SAT_EN
  logic [FIBO_W:0] sum;
  logic            ovf_a_reg;
  logic            ovf_b_reg;
  logic            ovf_b_next;

  // Once either operand has overflowed every later term is too large as well.
  always_comb begin
    sum        = {1'b0, a_reg} + {1'b0, b_reg};
    ovf_b_next = ovf_a_reg | ovf_b_reg | sum[FIBO_W];
    b_next     = ovf_b_next ? '1 : sum[FIBO_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_a_reg <= 1'b0;
      ovf_b_reg <= 1'b0;
    end else if (load) begin
      ovf_a_reg <= 1'b0;
      ovf_b_reg <= 1'b0;
    end else if (step) begin
      ovf_a_reg <= ovf_b_reg;
      ovf_b_reg <= ovf_b_next;
    end
  end

  assign result = ovf_a_reg ? '1 : a_reg;
  assign ovf    = ovf_a_reg;
`else
  assign b_next = a_reg + b_reg;
  assign result = a_reg;
  assign ovf    = 1'b0;
`endif

endmodule

// File: rtl/fibo_sched.sv
// Round-robin scheduler sharing one fibo_core among N_REQ requesters.
// Saturating arithmetic is selected inside fibo_core by FIBO_SAT_EN.
module fibo_sched import fibo_pkg::*; #(
  parameter int N_REQ  = 4,
  parameter int ID_W   = $clog2(N_REQ),
  parameter int FIBO_W = FIBO_W_DFLT
) (
  input logic         clk,
  input logic         reset_n,
  fibo_sched_if.slave bus
);

  fibo_state_t       state_reg;
  fibo_state_t       state_next;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [ID_W-1:0]   id_reg;
  logic [ID_W-1:0]   rsp_id_reg;
  logic [FIBO_W-1:0] rsp_data_reg;
  logic              rsp_ovf_reg;

  logic [IDX_W-1:0]  idx_slice [N_REQ];
  logic [IDX_W-1:0]  win_idx;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   scan_pos;
  logic              win_found;
  logic              grant;

  logic              core_step;
  logic              core_done;
  logic [FIBO_W-1:0] core_result;
  logic              core_ovf;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign idx_slice[gi]  = bus.req_idx[gi*IDX_W +: IDX_W];
      assign bus.gnt[gi]    = grant && (win_id == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_pos  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_pos = ID_W'((int'(rr_ptr_reg) + k) % N_REQ);
      if (!win_found && bus.req[scan_pos]) begin
        win_found = 1'b1;
        win_id    = scan_pos;
      end
    end
  end

  assign win_idx = idx_slice[win_id];

  // Gating with reset_n keeps the combinational grant quiet while reset is held.
  assign grant     = reset_n && (state_reg == IDLE) && win_found;
  assign core_step = (state_reg == CALC) && !core_done;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (win_found) state_next = CALC;
      CALC:    if (core_done) state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      id_reg       <= '0;
      rsp_id_reg   <= '0;
      rsp_data_reg <= '0;
      rsp_ovf_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant) begin
        id_reg     <= win_id;
        rr_ptr_reg <= ID_W'(rr_next(32'(win_id), N_REQ));
      end
      if (state_reg == CALC && core_done) begin
        rsp_id_reg   <= id_reg;
        rsp_data_reg <= core_result;
        rsp_ovf_reg  <= core_ovf;
      end
    end
  end

  fibo_core #(.FIBO_W(FIBO_W)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (grant),
    .idx     (win_idx),
    .step    (core_step),
    .done    (core_done),
    .result  (core_result),
    .ovf     (core_ovf)
  );

  assign bus.busy      = (state_reg != IDLE);
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_ovf   = rsp_ovf_reg;

endmodule

// File: doc/fibo_sched.md
Name: fibo_sched

Overview:
- Shares one iterative Fibonacci engine among N_REQ requesters.
- Round-robin arbitration selects one pending request, latches its 5-bit index, sequences the engine for n steps, then returns F(n) with the requester ID on a valid/ready response port.
- Sits between client blocks (UI/test sequencer) and the Fibonacci datapath, replacing the ad-hoc begin_fibo stepping with a self-timed controller.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), width of requester ID.
- FIBO_W, 16, result width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request level; held until matching gnt bit.
- req_idx  in  N_REQ*5  packed indices; slice i = bits [5i+4:5i], range 0..31.
- gnt  out  N_REQ  one-hot, one-cycle pulse; accepts the request.
- busy  out  1  high in CALC or RESP.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_W  requester that owns the result.
- rsp_data  out  FIBO_W  F(n).
- rsp_ovf  out  1  result exceeded FIBO_W (see Optional Feature).

Behaviour:
- Definition: F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2).
- Reset (async): state=IDLE, rr_ptr=0, gnt=0, busy=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_ovf=0, internal a=0, b=1, cnt=0.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - If any req bit is high, grant the first set bit found scanning from rr_ptr upward with wrap-around.
  - gnt is combinational and valid only in IDLE, pulsing for exactly that cycle.
  - Same edge: latch idx=req_idx[slice], id, a=0, b=1, cnt=idx; rr_ptr=(granted+1) mod N_REQ; go to CALC.
  - If no req, stay in IDLE.
- CALC:
  - If cnt==0: rsp_data<=a, rsp_id<=id, go to RESP.
  - Else: a<=b, b<=a+b, cnt<=cnt-1.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_ovf held stable.
  - On rsp_valid&&rsp_ready, go to IDLE.
  - No grant is issued in the handshake cycle; the next grant comes at the earliest in the following IDLE cycle.
- Latency: with gnt in cycle 0, rsp_valid first rises in cycle n+2 (n=0 gives cycle 2; n=31 gives cycle 33).
- Throughput: at most one request per n+3 cycles when rsp_ready is tied high.
- Requester rules:
  - May drop req only after its gnt; dropping earlier withdraws the request, with no side effects.
  - req_idx is sampled only in the gnt cycle.
- Arithmetic: additions are FIBO_W-bit, unsigned; carry-out handling is per Optional Feature.
- Simultaneous events:
  - req arriving during CALC/RESP is ignored until IDLE, with no loss because req is level.
  - The requester just granted may re-request immediately; it is serviced after the others that are pending.
- Reset mid-operation returns to IDLE instantly. The in-flight result is discarded; rsp_valid drops asynchronously.
- Unused bits of req_idx slices beyond N_REQ do not exist; idx values above 31 cannot occur.

Optional Feature:
- Macro: FIBO_SAT_EN.
- Defined:
  - Per-register overflow flags ovf_a and ovf_b.
  - On each step, ovf_b<=ovf_a|ovf_b|carry(a+b) and ovf_a<=ovf_b. When b's new flag is set, b saturates to all-ones.
  - rsp_data=a (all-ones if ovf_a); rsp_ovf=ovf_a.
  - For FIBO_W=16: n<=24 gives the exact result with rsp_ovf=0; n>=25 gives 16'hFFFF with rsp_ovf=1.
- Undefined:
  - Sums wrap modulo 2^FIBO_W.
  - rsp_ovf is tied to 0.
  - The flag logic is absent.

Decomposition:
- Package fibo_pkg: IDX_W=5, default FIBO_W=16, state enum fibo_state_t {IDLE, CALC, RESP}, and the result struct {id, data, ovf}.
- Sub-module fibo_core: the a/b/cnt datapath.
  - Inputs: load, idx, step.
  - Outputs: done (cnt==0), result, ovf.
  - Contains the FIBO_SAT_EN logic.
- fibo_sched contains the arbiter and the FSM.

Test Plan:
- Single requester 0, idx=0, then 1, then 10 (rsp_ready=1): rsp_data = 0, 1, 55; rsp_valid rises at cycles 2, 3, 12 after gnt; rsp_id=0.
- idx=24 gives 46368 with rsp_ovf=0. idx=25 gives 9489 without FIBO_SAT_EN, or 16'hFFFF with rsp_ovf=1 with it. idx=31 gives 35549, or 16'hFFFF with rsp_ovf=1.
- All 4 req high from reset with idx=i+5: grants occur in order 0,1,2,3; results 5,8,13,21 carry matching rsp_id; each gnt is a single-cycle one-hot pulse.
- req0 re-asserted right after its grant while req2 is pending: the next grant goes to 2, then 0.
- idx=7 with rsp_ready low for 5 cycles after rsp_valid: rsp_valid/rsp_data=13/rsp_id stay stable; no gnt occurs until one cycle after the handshake.
- reset_n pulsed low in the middle of an idx=20 CALC: all outputs are at reset values immediately. After release, a new idx=3 request returns 2 with correct latency.
